uart_tx_buffer: RTL and testbench
=================================

# uart_tx_buffer

Byte queue between the CPU core's output port and `uart_tx`. The core writes bytes at full clock rate. The block stores them in a FIFO and drains them one at a time into `uart_tx` using the `sdata`/`tx_start`/`tx_busy` handshake. This removes per-byte transmitter polling from the core and from test drivers.

## Interface
- `DEPTH`, 16: FIFO entries in bytes; must be a power of two, at least 2.
- `clk`  input  1  system clock; shared with `uart_tx`.
- `rst_uart`  input  1  reset; synchronous, active-high.
- `wr_en`  input  1  push `wr_data` this cycle.
- `wr_data`  input  8  byte to queue.
- `full`  output  1  FIFO holds `DEPTH` bytes.
- `empty`  output  1  FIFO holds 0 bytes.
- `count`  output  $clog2(DEPTH)+1  current occupancy.
- `sdata`  output  8  byte presented to `uart_tx`.
- `tx_start`  output  1  transmit request to `uart_tx`.
- `tx_busy`  input  1  busy flag from `uart_tx`.
- `active`  output  1  high when the FIFO is non-empty or the FSM is not IDLE.

## Operation
- The FIFO has read and write pointers of width $clog2(DEPTH), which wrap modulo `DEPTH`, and a registered `count`.
- Push:
  - A push is accepted when `wr_en` is high and `full` is low.
  - `wr_en` while `full` is high: the byte is dropped silently and no state changes.
  - `full` is evaluated from registered `count`. A push and a pop in the same cycle while full still rejects the push.
- Push and pop in the same cycle (not full): `count` is unchanged and both pointers advance.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
  - IDLE with `empty` low: `sdata` <= head byte, pop, go to START.
  - START: `tx_start` <= 1, go to WAIT_BUSY.
  - WAIT_BUSY: when `tx_busy` is high, `tx_start` <= 0 and go to WAIT_DONE. Otherwise hold `tx_start` high.
  - WAIT_DONE: when `tx_busy` is low, go to IDLE.
- `sdata` holds its value from pop until the next pop.
- Reset values: state IDLE, both pointers 0, `count` 0, `sdata` 8'h00, `tx_start` 0.
  - Consequently `empty`=1, `full`=0, `active`=0.
- Reset mid-transfer: the FIFO contents are discarded and `tx_start` drops on the next cycle. `uart_tx` shares the same reset.
- `wr_data` pushes are never blocked by the FSM state.

## Timing
- Latency from write to request:
  - `wr_en` is sampled at edge 0 with the FIFO empty and the FSM in IDLE.
  - `count`=1 after edge 0.
  - Pop and `sdata` valid after edge 1.
  - `tx_start`=1 after edge 2.
- `tx_start` stays high until the first cycle `tx_busy` is seen high, then falls at the next edge.
- Back-to-back bytes: the next pop happens one cycle after WAIT_DONE observes `tx_busy` low.
- Throughput is limited by the UART (about 20·`CLK_PER_HALF_BIT` cycles per byte). The FSM adds 3 cycles per byte.
- `full`, `empty`, and `count` update the cycle after the push or pop edge.

## Configuration
- Macro: `UART_TX_BUF_CRLF_EN`.
- Defined:
  - When the head byte is 8'h0a and the internal `cr_done` flag is clear, IDLE loads `sdata` <= 8'h0d without popping and sets `cr_done`.
  - After that byte completes, IDLE pops the 8'h0a normally and clears `cr_done`.
  - Each LF costs one extra UART frame. `cr_done` resets to 0.
- Undefined: all bytes pass through unchanged. No `cr_done` register exists.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (`TXB_IDLE`, `TXB_START`, `TXB_WAIT_BUSY`, `TXB_WAIT_DONE`);
  - `ASCII_LF` = 8'h0a and `ASCII_CR` = 8'h0d.
- One sub-module, `byte_fifo`: parameterised by `DEPTH`, with push/pop/full/empty/count.
- The FSM and CRLF logic stay in `uart_tx_buffer`.

## Test plan
- Single byte: push 8'haa into an empty buffer.
  - `tx_start` rises 2 cycles later.
  - `sdata`=8'haa.
  - `uart_tx` serialises 8'haa.
  - `active` falls after `tx_busy` falls.
- Burst: push "P3\n" (8'h50, 8'h33, 8'h0a) on consecutive cycles.
  - `count` reaches 2–3.
  - Bytes go out in order with no loss.
  - `empty`=1 at the end.
- Overflow with DEPTH=4 and the UART held busy:
  - Push 6 bytes 0x31..0x36.
  - `full`=1 after 4.
  - Output is 0x31..0x34; 0x35 and 0x36 are dropped.
- Simultaneous push and pop: push on the exact cycle IDLE pops with `count`=1.
  - `count` stays 1.
  - The next byte follows correctly.
- Reset mid-frame: assert `rst_uart` while in WAIT_DONE with 3 bytes queued.
  - Next cycle: `tx_start`=0, `count`=0, `sdata`=0, state IDLE.
  - No queued byte is transmitted afterwards.
- With `UART_TX_BUF_CRLF_EN`: push 8'h41, 8'h0a.
  - The wire carries 8'h41, 8'h0d, 8'h0a.
  - Without the macro, the wire carries 8'h41, 8'h0a.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: buffer FSM states and ASCII codes.
package uart_pkg;

    typedef enum logic [1:0] {
        TXB_IDLE      = 2'd0,
        TXB_START     = 2'd1,
        TXB_WAIT_BUSY = 2'd2,
        TXB_WAIT_DONE = 2'd3
    } txb_state_e;

    localparam logic [7:0] ASCII_LF = 8'h0a;
    localparam logic [7:0] ASCII_CR = 8'h0d;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrapping pointers and a registered occupancy count.
// DEPTH must be a power of two, at least 2; full/empty derive from the registered count.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [7:0]               wr_data_i,
    input  logic                     pop_i,
    output logic [7:0]               rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    import uart_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A push while full is dropped even if a pop happens in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte queue feeding uart_tx through the sdata/tx_start/tx_busy handshake.
// Optional macro UART_TX_BUF_CRLF_EN inserts a CR ahead of every LF on the wire.
module uart_tx_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_uart,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               sdata,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     active
);
    import uart_pkg::*;

    txb_state_e state_q, state_d;
    logic [7:0] sdata_q, sdata_d;
    logic       tx_start_q, tx_start_d;
    logic       pop;
    logic [7:0] head;
    logic       fifo_empty;
`ifdef UART_TX_BUF_CRLF_EN
    logic       cr_done_q, cr_done_d;
`endif

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst_uart),
        .push_i    (wr_en),
        .wr_data_i (wr_data),
        .pop_i     (pop),
        .rd_data_o (head),
        .full_o    (full),
        .empty_o   (fifo_empty),
        .count_o   (count)
    );

    assign empty    = fifo_empty;
    assign sdata    = sdata_q;
    assign tx_start = tx_start_q;
    assign active   = !fifo_empty || (state_q != TXB_IDLE);

    always_comb begin
        state_d    = state_q;
        sdata_d    = sdata_q;
        tx_start_d = tx_start_q;
        pop        = 1'b0;
`ifdef UART_TX_BUF_CRLF_EN
        cr_done_d  = cr_done_q;
`endif
        case (state_q)
            TXB_IDLE: begin
                if (!fifo_empty) begin
                    state_d = TXB_START;
`ifdef UART_TX_BUF_CRLF_EN
                    // LF stays at the head while its CR goes out first.
                    if (head == ASCII_LF && !cr_done_q) begin
                        sdata_d   = ASCII_CR;
                        cr_done_d = 1'b1;
                    end else begin
                        sdata_d   = head;
                        pop       = 1'b1;
                        cr_done_d = 1'b0;
                    end
`else
                    sdata_d = head;
                    pop     = 1'b1;
`endif
                end
            end
            TXB_START: begin
                tx_start_d = 1'b1;
                state_d    = TXB_WAIT_BUSY;
            end
            TXB_WAIT_BUSY: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = TXB_WAIT_DONE;
                end
            end
            TXB_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = TXB_IDLE;
                end
            end
            default: state_d = TXB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_uart) begin
            state_q    <= TXB_IDLE;
            sdata_q    <= 8'h00;
            tx_start_q <= 1'b0;
`ifdef UART_TX_BUF_CRLF_EN
            cr_done_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sdata_q    <= sdata_d;
            tx_start_q <= tx_start_d;
`ifdef UART_TX_BUF_CRLF_EN
            cr_done_q  <= cr_done_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomized and directed bench for uart_tx_buffer against a byte-stream reference model.
module tb_uart_tx_buffer;

    localparam int TB_DEPTH = 4;
    localparam logic [7:0] LF = 8'h0a;
    localparam logic [7:0] CR = 8'h0d;

    logic       clk = 1'b0;
    logic       rst_uart;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic [7:0] sdata;
    logic       tx_start;
    logic       tx_busy;
    logic       active;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural UART: accepts tx_start when idle, stays busy for busy_len+1 cycles or while held.
    logic       busy_q;
    int         busy_cnt;
    int         busy_len;
    logic       hold_busy;
    logic [7:0] wire_q [$];
    logic [7:0] exp_q [$];
    int         wire_base;

    assign tx_busy = busy_q;

    uart_tx_buffer #(.DEPTH(TB_DEPTH)) dut (
        .clk      (clk),
        .rst_uart (rst_uart),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .sdata    (sdata),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .active   (active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_uart) begin
            busy_q   <= 1'b0;
            busy_cnt <= 0;
        end else if (busy_q) begin
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            else if (!hold_busy) busy_q <= 1'b0;
        end else if (tx_start) begin
            busy_q   <= 1'b1;
            busy_cnt <= busy_len;
            wire_q.push_back(sdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_byte(input logic [7:0] b);
`ifdef UART_TX_BUF_CRLF_EN
        if (b == LF) exp_q.push_back(CR);
`endif
        exp_q.push_back(b);
    endtask

    task automatic push_one(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (!active && !busy_q) break;
        end
        chk({tag, "_idle"}, 32'(active | busy_q), 32'd0);
    endtask

    task automatic wait_busy(input string tag, input logic val);
        for (int i = 0; i < 3000; i++) begin
            if (busy_q == val) break;
            @(posedge clk);
            #1;
        end
        chk({tag, "_busywait"}, 32'(busy_q), 32'(val));
    endtask

    task automatic check_wire(input string tag);
        int n;
        n = wire_q.size() - wire_base;
        chk({tag, "_nbytes"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < n) chk({tag, "_byte"}, 32'(wire_q[wire_base + i]), 32'(exp_q[i]));
        end
        wire_base = wire_q.size();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_uart  = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        hold_busy = 1'b0;
        busy_len  = 4;
        wire_base = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_txstart", 32'(tx_start), 32'd0);
        chk("rst_sdata", 32'(sdata), 32'd0);
        rst_uart = 1'b0;
        @(posedge clk);
        #1;

        // Single byte: count after edge 0, pop after edge 1, request after edge 2.
        push_one(8'haa);
        expect_byte(8'haa);
        chk("sb_count_e0", 32'(count), 32'd1);
        chk("sb_txs_e0", 32'(tx_start), 32'd0);
        @(posedge clk);
        #1;
        chk("sb_sdata_e1", 32'(sdata), 32'haa);
        chk("sb_count_e1", 32'(count), 32'd0);
        chk("sb_txs_e1", 32'(tx_start), 32'd0);
        @(posedge clk);
        #1;
        chk("sb_txs_e2", 32'(tx_start), 32'd1);
        wait_busy("sb_rise", 1'b1);
        wait_busy("sb_fall", 1'b0);
        chk("sb_active_hold", 32'(active), 32'd1);
        @(posedge clk);
        #1;
        chk("sb_active_fall", 32'(active), 32'd0);
        check_wire("sb");

        // Burst "P3\n": first byte pops on the second push edge.
        push_one(8'h50);
        push_one(8'h33);
        push_one(LF);
        expect_byte(8'h50);
        expect_byte(8'h33);
        expect_byte(LF);
        chk("burst_count", 32'(count), 32'd2);
        wait_idle("burst");
        chk("burst_empty", 32'(empty), 32'd1);
        check_wire("burst");

        // Push on the exact edge that pops the only entry.
        push_one(8'h5a);
        chk("pp_count_a", 32'(count), 32'd1);
        push_one(8'ha5);
        chk("pp_count_b", 32'(count), 32'd1);
        expect_byte(8'h5a);
        expect_byte(8'ha5);
        wait_idle("pp");
        check_wire("pp");

        // CR insertion (or plain pass-through) around an LF.
        push_one(8'h41);
        push_one(LF);
        expect_byte(8'h41);
        expect_byte(LF);
        wait_idle("crlf");
        check_wire("crlf");

        // Overflow: one byte in flight, UART held busy, six more pushed.
        hold_busy = 1'b1;
        busy_len  = 2;
        push_one(8'h30);
        expect_byte(8'h30);
        wait_busy("ovf", 1'b1);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            push_one(8'h31 + 8'(i));
            if (i < TB_DEPTH) expect_byte(8'h31 + 8'(i));
            if (i == TB_DEPTH - 1) chk("ovf_full", 32'(full), 32'd1);
        end
        chk("ovf_count", 32'(count), 32'(TB_DEPTH));
        hold_busy = 1'b0;
        wait_idle("ovf");
        chk("ovf_empty", 32'(empty), 32'd1);
        check_wire("ovf");

        // Reset while in WAIT_DONE with three bytes queued.
        hold_busy = 1'b1;
        push_one(8'h61);
        expect_byte(8'h61);
        wait_busy("rmf", 1'b1);
        repeat (2) @(posedge clk);
        #1;
        push_one(8'h62);
        push_one(8'h63);
        push_one(8'h64);
        chk("rmf_count_pre", 32'(count), 32'd3);
        rst_uart = 1'b1;
        @(posedge clk);
        #1;
        rst_uart  = 1'b0;
        hold_busy = 1'b0;
        chk("rmf_txstart", 32'(tx_start), 32'd0);
        chk("rmf_count", 32'(count), 32'd0);
        chk("rmf_sdata", 32'(sdata), 32'd0);
        chk("rmf_active", 32'(active), 32'd0);
        repeat (100) @(posedge clk);
        #1;
        check_wire("rmf");

        // Random bursts no larger than the FIFO, random gaps and UART frame lengths.
        for (int r = 0; r < 12; r++) begin
            int n;
            busy_len = $urandom_range(1, 20);
            n = $urandom_range(1, TB_DEPTH);
            for (int k = 0; k < n; k++) begin
                logic [7:0] b;
                b = ($urandom_range(0, 4) == 0) ? LF : 8'($urandom);
                push_one(b);
                expect_byte(b);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            wait_idle("rnd");
            chk("rnd_empty", 32'(empty), 32'd1);
            chk("rnd_count", 32'(count), 32'd0);
            check_wire("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
